icache: RTL

- Direct-mapped, read-only instruction cache directly upstream of the fetch stage.
- Accepts a halfword-aligned fetch PC plus a level fetch-enable from fetch.
- Returns one instruction word per delivery pulse.
- Refills 16-byte lines from the memory controller over a word-serial request/valid interface.
- Handles RVC: a 32-bit instruction may straddle two lines.

---
 rtl/icache_pkg.sv | 25 ++
 rtl/icache_array.sv | 55 +++++
 rtl/icache.sv | 137 +++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// Shared widths, FSM state encoding and line-access helper for the instruction cache.
package icache_pkg;

  localparam int unsigned ADDR_WIDTH        = 32;
  localparam int unsigned INST_WIDTH        = 32;
  localparam int unsigned ICACHE_INDEX_BITS = 6;
  localparam int unsigned LINE_OFF_BITS     = 4;
  localparam int unsigned LINE_WORDS        = 4;

  typedef enum logic [1:0] {
    StIdle,
    StResp,
    StRefill,
    StBubble
  } icache_state_e;

  // Extract halfword number off (0..7) from a 16-byte line.
  function automatic logic [15:0] line_half(input logic [LINE_WORDS-1:0][31:0] line,
                                            input logic [2:0] off);
    logic [31:0] word;
    word = line[off[2:1]];
    return off[0] ? word[31:16] : word[15:0];
  endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: one word-granular refill write port, two combinational line reads.
module icache_array #(
  parameter int unsigned TagBits   = 22,
  parameter int unsigned IndexBits = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 we_i,
  input  logic                 last_i,
  input  logic [IndexBits-1:0] wr_idx_i,
  input  logic [1:0]           wr_word_i,
  input  logic [TagBits-1:0]   wr_tag_i,
  input  logic [31:0]          wr_data_i,
  input  logic [IndexBits-1:0] rd0_idx_i,
  input  logic [IndexBits-1:0] rd1_idx_i,
  output logic                 rd0_valid_o,
  output logic                 rd1_valid_o,
  output logic [TagBits-1:0]   rd0_tag_o,
  output logic [TagBits-1:0]   rd1_tag_o,
  output logic [3:0][31:0]     rd0_line_o,
  output logic [3:0][31:0]     rd1_line_o
);

  localparam int unsigned NumLines = 1 << IndexBits;

  logic [NumLines-1:0] valid_q;
  logic [TagBits-1:0]  tag_q  [NumLines];
  logic [3:0][31:0]    data_q [NumLines];

  // A line being refilled stays invalid until its final word lands.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx_i] <= last_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      data_q[wr_idx_i][wr_word_i] <= wr_data_i;
      if (last_i) begin
        tag_q[wr_idx_i] <= wr_tag_i;
      end
    end
  end

  assign rd0_valid_o = valid_q[rd0_idx_i];
  assign rd1_valid_o = valid_q[rd1_idx_i];
  assign rd0_tag_o   = tag_q[rd0_idx_i];
  assign rd1_tag_o   = tag_q[rd1_idx_i];
  assign rd0_line_o  = data_q[rd0_idx_i];
  assign rd1_line_o  = data_q[rd1_idx_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with word-serial refill and RVC line-straddle support.
module icache #(
  parameter int unsigned ADDR_WIDTH = icache_pkg::ADDR_WIDTH,
  parameter int unsigned INDEX_BITS = icache_pkg::ICACHE_INDEX_BITS
) (
  input  logic                              clk,
  input  logic                              rst_in,
  input  logic                              rdy_in,
  input  logic                              flush,
  input  logic                              fetch_en,
  input  logic [ADDR_WIDTH-1:0]             fetch_pc,
  output logic                              inst_rdy,
  output logic [icache_pkg::INST_WIDTH-1:0] inst_out,
  output logic                              mem_req,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  input  logic                              mem_valid,
  input  logic [31:0]                       mem_data
);

  import icache_pkg::*;

  localparam int unsigned LineBits = ADDR_WIDTH - LINE_OFF_BITS;
  localparam int unsigned TagBits  = LineBits - INDEX_BITS;

  icache_state_e         state_q, state_d;
  logic [LineBits-1:0]   fill_line_q, fill_line_d;
  logic [1:0]            word_cnt_q, word_cnt_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;

  logic [LineBits-1:0] line0, line1;
  logic                v0, v1, hit0, hit1;
  logic [TagBits-1:0]  t0, t1;
  logic [3:0][31:0]    d0, d1;
  logic [2:0]          off1;
  logic [15:0]         lo, hi;
  logic                straddle;
  logic                we, last;
  logic                unused_pc0;

  assign unused_pc0 = fetch_pc[0];
  assign line0      = fetch_pc[ADDR_WIDTH-1:LINE_OFF_BITS];
  assign line1      = line0 + LineBits'(1);

  icache_array #(
    .TagBits  (TagBits),
    .IndexBits(INDEX_BITS)
  ) u_array (
    .clk_i      (clk),
    .rst_i      (rst_in),
    .we_i       (we),
    .last_i     (last),
    .wr_idx_i   (fill_line_q[INDEX_BITS-1:0]),
    .wr_word_i  (word_cnt_q),
    .wr_tag_i   (fill_line_q[LineBits-1:INDEX_BITS]),
    .wr_data_i  (mem_data),
    .rd0_idx_i  (line0[INDEX_BITS-1:0]),
    .rd1_idx_i  (line1[INDEX_BITS-1:0]),
    .rd0_valid_o(v0),
    .rd1_valid_o(v1),
    .rd0_tag_o  (t0),
    .rd1_tag_o  (t1),
    .rd0_line_o (d0),
    .rd1_line_o (d1)
  );

  assign hit0     = v0 && (t0 == line0[LineBits-1:INDEX_BITS]);
  assign hit1     = v1 && (t1 == line1[LineBits-1:INDEX_BITS]);
  assign off1     = fetch_pc[3:1] + 3'd1;
  assign lo       = line_half(d0, fetch_pc[3:1]);
  assign straddle = (fetch_pc[3:1] == 3'd7) && (lo[1:0] == 2'b11);
  // The upper half lives in the next line only when the instruction straddles.
  assign hi       = straddle ? d1[0][15:0] : line_half(d0, off1);

  always_comb begin
    state_d     = state_q;
    fill_line_d = fill_line_q;
    word_cnt_d  = word_cnt_q;
    inst_d      = inst_q;
    we          = 1'b0;
    last        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fetch_en && !flush) begin
          if (!hit0) begin
            state_d     = StRefill;
            fill_line_d = line0;
            word_cnt_d  = 2'd0;
          end else if (straddle && !hit1) begin
            state_d     = StRefill;
            fill_line_d = line1;
            word_cnt_d  = 2'd0;
          end else begin
            state_d = StResp;
            inst_d  = (lo[1:0] == 2'b11) ? {hi, lo} : {16'b0, lo};
          end
        end
      end
      StResp:   state_d = StBubble;
      StBubble: state_d = StIdle;
      StRefill: begin
        if (mem_valid && rdy_in) begin
          we         = 1'b1;
          word_cnt_d = word_cnt_q + 2'd1;
          if (word_cnt_q == 2'd3) begin
            last    = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // A refill always runs to completion; flush only takes effect outside it.
    if (flush && (state_q != StRefill)) begin
      state_d = StBubble;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q     <= StIdle;
      fill_line_q <= '0;
      word_cnt_q  <= '0;
      inst_q      <= '0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      fill_line_q <= fill_line_d;
      word_cnt_q  <= word_cnt_d;
      inst_q      <= inst_d;
    end
  end

  assign inst_rdy = (state_q == StResp) && !flush;
  assign inst_out = inst_q;
  assign mem_req  = (state_q == StRefill);
  assign mem_addr = mem_req ? {fill_line_q, word_cnt_q, 2'b00} : '0;

endmodule
